// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: byte width and default FIFO depth.
package uart_pkg;
  localparam int unsigned BYTE_W          = 8;
  localparam int unsigned FIFO_DEPTH_LOG2 = 4;
endpackage

// File: rtl/uart_fifo_mem.sv
// Byte storage for uart_rx_fifo: synchronous write, registered read, no reset.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int unsigned ADDR_W = FIFO_DEPTH_LOG2
) (
  input  logic              clk_i,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [BYTE_W-1:0] rd_data
);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [BYTE_W-1:0] mem [0:DEPTH-1];

  // Read returns the pre-write contents when both ports hit the same slot.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind a UART receiver with sticky overrun and level interrupt.
// Define UART_RX_FIFO_THRESH_IRQ_EN for a count-threshold interrupt instead of not-empty.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = FIFO_DEPTH_LOG2,
  parameter int unsigned RX_THRESH  = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  rx_valid_i,
  input  logic [BYTE_W-1:0]     rx_data_i,
  input  logic                  rd_en_i,
  input  logic                  flush_i,
  input  logic                  ovr_clr_i,
  output logic [BYTE_W-1:0]     rd_data_o,
  output logic                  rd_valid_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  overrun_o,
  output logic                  irq_o
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;

  if (DEPTH_LOG2 < 2 || DEPTH_LOG2 > 8) begin : g_bad_depth
    $error("uart_rx_fifo: DEPTH_LOG2 out of range");
  end
  if (RX_THRESH < 1 || RX_THRESH > DEPTH) begin : g_bad_thresh
    $error("uart_rx_fifo: RX_THRESH out of range");
  end

  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]         count, count_nxt;
  logic                  overrun, ovr_nxt, irq_nxt;
  logic                  rd_ok, wr_ok, ovr_set;
  logic                  rd_loaded;
  logic [BYTE_W-1:0]     mem_q;

  assign empty_o   = (count == '0);
  assign full_o    = (count == CW'(DEPTH));
  assign count_o   = count;
  assign overrun_o = overrun;
  // Storage has no reset, so hide its output until the first real read.
  assign rd_data_o = rd_loaded ? mem_q : '0;

  always_comb begin
    rd_ok     = rd_en_i & ~empty_o & ~flush_i;
    wr_ok     = rx_valid_i & (~full_o | rd_en_i) & ~flush_i;
    ovr_set   = rx_valid_i & full_o & ~rd_en_i & ~flush_i;
    count_nxt = count;
    ovr_nxt   = overrun;
    if (flush_i) begin
      count_nxt = '0;
    end else begin
      count_nxt = count + {{(CW-1){1'b0}}, wr_ok} - {{(CW-1){1'b0}}, rd_ok};
      ovr_nxt   = ovr_set | (overrun & ~ovr_clr_i);
    end
`ifdef UART_RX_FIFO_THRESH_IRQ_EN
    irq_nxt = (count_nxt >= CW'(RX_THRESH)) | ovr_nxt;
`else
    irq_nxt = (count_nxt != '0) | ovr_nxt;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overrun    <= 1'b0;
      rd_valid_o <= 1'b0;
      irq_o      <= 1'b0;
      rd_loaded  <= 1'b0;
    end else begin
      if (flush_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_ok) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
        if (rd_ok) rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      end
      count      <= count_nxt;
      overrun    <= ovr_nxt;
      irq_o      <= irq_nxt;
      rd_valid_o <= rd_ok;
      if (rd_ok) rd_loaded <= 1'b1;
    end
  end

  uart_fifo_mem #(
    .ADDR_W(DEPTH_LOG2)
  ) u_mem (
    .clk_i  (clk_i),
    .wr_en  (wr_ok & ~reset_i),
    .wr_addr(wr_ptr),
    .wr_data(rx_data_i),
    .rd_en  (rd_ok & ~reset_i),
    .rd_addr(rd_ptr),
    .rd_data(mem_q)
  );
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo (DEPTH_LOG2=4, RX_THRESH=8) against a queue model.
module tb_uart_rx_fifo;
  localparam int unsigned DL2 = 4;
  localparam int unsigned DEP = 16;
  localparam int unsigned THR = 8;

  logic       clk = 1'b0;
  logic       reset_i = 1'b0, rx_valid_i = 1'b0, rd_en_i = 1'b0;
  logic       flush_i = 1'b0, ovr_clr_i = 1'b0;
  logic [7:0] rx_data_i = '0;
  logic [7:0] rd_data_o;
  logic       rd_valid_o, empty_o, full_o, overrun_o, irq_o;
  logic [4:0] count_o;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .DEPTH_LOG2(DL2),
    .RX_THRESH (THR)
  ) dut (
    .clk_i     (clk),
    .reset_i   (reset_i),
    .rx_valid_i(rx_valid_i),
    .rx_data_i (rx_data_i),
    .rd_en_i   (rd_en_i),
    .flush_i   (flush_i),
    .ovr_clr_i (ovr_clr_i),
    .rd_data_o (rd_data_o),
    .rd_valid_o(rd_valid_o),
    .count_o   (count_o),
    .empty_o   (empty_o),
    .full_o    (full_o),
    .overrun_o (overrun_o),
    .irq_o     (irq_o)
  );

  // Reference model: contents as a plain queue plus the visible flags.
  logic [7:0] mq[$];
  bit         m_ovr;
  bit         m_rdv;
  logic [7:0] m_rdd;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_irq();
`ifdef UART_RX_FIFO_THRESH_IRQ_EN
    return (mq.size() >= THR) || m_ovr;
`else
    return (mq.size() != 0) || m_ovr;
`endif
  endfunction

  task automatic model_step(input bit rst, input bit rxv, input logic [7:0] d,
                            input bit rde, input bit fl, input bit oc);
    bit was_full;
    if (rst) begin
      mq.delete();
      m_ovr = 0;
      m_rdv = 0;
      m_rdd = 8'h00;
    end else if (fl) begin
      mq.delete();
      m_rdv = 0;
    end else begin
      was_full = (mq.size() == DEP);
      m_rdv = rde && (mq.size() != 0);
      if (m_rdv) m_rdd = mq.pop_front();
      if (rxv && (!was_full || rde)) mq.push_back(d);
      m_ovr = (rxv && was_full && !rde) || (m_ovr && !oc);
    end
  endtask

  // One clock: drive mid-cycle, step model at the edge, compare just after it.
  task automatic cycle(input bit rst, input bit rxv, input logic [7:0] d,
                       input bit rde, input bit fl, input bit oc);
    @(negedge clk);
    reset_i = rst; rx_valid_i = rxv; rx_data_i = d;
    rd_en_i = rde; flush_i = fl; ovr_clr_i = oc;
    @(posedge clk);
    model_step(rst, rxv, d, rde, fl, oc);
    #1;
    chk("count",    count_o,    mq.size());
    chk("empty",    empty_o,    mq.size() == 0);
    chk("full",     full_o,     mq.size() == DEP);
    chk("overrun",  overrun_o,  m_ovr);
    chk("rd_valid", rd_valid_o, m_rdv);
    chk("rd_data",  rd_data_o,  m_rdd);
    chk("irq",      irq_o,      model_irq());
  endtask

  task automatic wr(input logic [7:0] d);  cycle(0, 1, d, 0, 0, 0); endtask
  task automatic rd();                     cycle(0, 0, 8'h00, 1, 0, 0); endtask
  task automatic rst_cycle();              cycle(1, 0, 8'h00, 0, 0, 0); endtask

  typedef struct {
    bit rst, rxv; logic [7:0] d; bit rde, fl, oc;
    int e_count; bit e_rdv; logic [7:0] e_rdd; bit e_ovr;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // Basic write/read ordering and read-when-empty behaviour.
    tbl.push_back('{1, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0});
    tbl.push_back('{0, 1, 8'hA5, 0, 0, 0, 1, 0, 8'h00, 0});
    tbl.push_back('{0, 1, 8'h3C, 0, 0, 0, 2, 0, 8'h00, 0});
    tbl.push_back('{0, 0, 8'h00, 1, 0, 0, 1, 1, 8'hA5, 0});
    tbl.push_back('{0, 0, 8'h00, 1, 0, 0, 0, 1, 8'h3C, 0});
    tbl.push_back('{0, 0, 8'h00, 1, 0, 0, 0, 0, 8'h3C, 0});
    tbl.push_back('{0, 1, 8'h77, 1, 0, 0, 1, 0, 8'h3C, 0});
    tbl.push_back('{0, 0, 8'h00, 1, 0, 0, 0, 1, 8'h77, 0});
    tbl.push_back('{0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h77, 0});

    rst_cycle();
    chk("reset_rd_data", rd_data_o, 8'h00);
    chk("reset_irq",     irq_o,     1'b0);
    chk("reset_empty",   empty_o,   1'b1);

    foreach (tbl[i]) begin
      cycle(tbl[i].rst, tbl[i].rxv, tbl[i].d, tbl[i].rde, tbl[i].fl, tbl[i].oc);
      chk($sformatf("tbl%0d_count", i), count_o,    tbl[i].e_count);
      chk($sformatf("tbl%0d_empty", i), empty_o,    tbl[i].e_count == 0);
      chk($sformatf("tbl%0d_rdv", i),   rd_valid_o, tbl[i].e_rdv);
      chk($sformatf("tbl%0d_rdd", i),   rd_data_o,  tbl[i].e_rdd);
      chk($sformatf("tbl%0d_ovr", i),   overrun_o,  tbl[i].e_ovr);
    end

    // Fill past capacity: 17th byte dropped, overrun set.
    rst_cycle();
    for (int i = 0; i < 17; i++) begin
      wr(8'(i));
      if (i == 14) chk("fill_not_full", full_o, 1'b0);
      if (i == 15) begin
        chk("fill_full", full_o, 1'b1);
        chk("fill_no_ovr", overrun_o, 1'b0);
      end
    end
    chk("fill_ovr", overrun_o, 1'b1);
    chk("fill_cnt", count_o, 5'd16);
    for (int i = 0; i < 16; i++) begin
      rd();
      chk("drain_rdv", rd_valid_o, 1'b1);
      chk("drain_data", rd_data_o, 8'(i));
    end
    rd();
    chk("drain_extra_rdv", rd_valid_o, 1'b0);
    chk("drain_extra_hold", rd_data_o, 8'h0F);

    // Full with simultaneous read and write: no overrun, new byte last.
    rst_cycle();
    for (int i = 0; i < 16; i++) wr(8'(8'h80 + i));
    cycle(0, 1, 8'h55, 1, 0, 0);
    chk("fullrw_cnt", count_o, 5'd16);
    chk("fullrw_ovr", overrun_o, 1'b0);
    chk("fullrw_data", rd_data_o, 8'h80);
    for (int i = 0; i < 16; i++) rd();
    chk("fullrw_last", rd_data_o, 8'h55);
    chk("fullrw_empty", empty_o, 1'b1);

    // Interrupt level.
    rst_cycle();
    for (int i = 0; i < 7; i++) begin
      wr(8'(i));
`ifdef UART_RX_FIFO_THRESH_IRQ_EN
      chk("irq_below", irq_o, 1'b0);
`else
      chk("irq_nonempty", irq_o, 1'b1);
`endif
    end
    wr(8'h07);
    chk("irq_at_thresh", irq_o, 1'b1);
    rd();
`ifdef UART_RX_FIFO_THRESH_IRQ_EN
    chk("irq_after_read", irq_o, 1'b0);
`else
    chk("irq_after_read", irq_o, 1'b1);
`endif

    // Flush with concurrent write keeps overrun, discards everything.
    rst_cycle();
    for (int i = 0; i < 17; i++) wr(8'(8'h40 + i));
    for (int i = 0; i < 11; i++) rd();
    chk("pre_flush_cnt", count_o, 5'd5);
    cycle(0, 1, 8'hEE, 0, 1, 0);
    chk("flush_cnt", count_o, 5'd0);
    chk("flush_empty", empty_o, 1'b1);
    chk("flush_ovr", overrun_o, 1'b1);
    rd();
    chk("flush_rd_none", rd_valid_o, 1'b0);

    // Overrun clear racing a new overrun, then clear alone, then reset mid-stream.
    for (int i = 0; i < 16; i++) wr(8'(i));
    cycle(0, 1, 8'h99, 0, 0, 1);
    chk("ovr_race", overrun_o, 1'b1);
    cycle(0, 0, 8'h00, 0, 0, 1);
    chk("ovr_clr", overrun_o, 1'b0);
    cycle(0, 1, 8'h12, 1, 0, 0);
    cycle(1, 1, 8'h34, 1, 0, 0);
    chk("midrst_cnt",  count_o,    5'd0);
    chk("midrst_empty", empty_o,   1'b1);
    chk("midrst_full", full_o,     1'b0);
    chk("midrst_ovr",  overrun_o,  1'b0);
    chk("midrst_rdd",  rd_data_o,  8'h00);
    chk("midrst_rdv",  rd_valid_o, 1'b0);
    chk("midrst_irq",  irq_o,      1'b0);

    // Randomized traffic; write/read bias changes per phase to reach full and empty.
    for (int p = 0; p < 15; p++) begin
      int unsigned wp = $urandom_range(20, 90);
      int unsigned rp = $urandom_range(20, 90);
      for (int c = 0; c < 200; c++) begin
        bit r   = ($urandom_range(0, 199) == 0);
        bit wv  = ($urandom_range(0, 99) < wp);
        bit rv  = ($urandom_range(0, 99) < rp);
        bit fl  = ($urandom_range(0, 99) < 2);
        bit oc  = ($urandom_range(0, 99) < 5);
        cycle(r, wv, 8'($urandom), rv, fl, oc);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
